// File: rtl/adder_mp_sequencer.sv
// Streaming multi-precision add/subtract sequencer: chains the carry across 128-bit words, LS word first.
// Optional signed-overflow output oOvf when ADDER_SEQ_OVF_EN is defined.

module adder_128bit #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oSum,
  output logic             oC
);
  assign {oC, oSum} = {1'b0, iA} + {1'b0, iB} + (WIDTH+1)'(iC);
endmodule

module adder_mp_sequencer #(
  parameter int unsigned ADDER_WIDTH = 128,
  parameter int unsigned MAX_WORDS   = 16
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iC,
  input  logic                   iSub,
  input  logic                   iFirst,
  input  logic                   iLast,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [ADDER_WIDTH-1:0] oSum,
  output logic                   oLast,
  output logic                   oC,
  output logic                   oErr
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic                   oOvf
`endif
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic                   carry_q, carry_d;
  logic                   mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [ADDER_WIDTH-1:0] sum_q, sum_d;
  logic                   last_q, last_d;
  logic                   c_q, c_d;
  logic                   err_q, err_d;

  logic                   accept, first_beat, sub_eff, cin, cout, len_err;
  logic [ADDER_WIDTH-1:0] b_eff, sum;
  logic [CNT_W:0]         cnt_next;

  // Any beat seen in IDLE starts a new operand; iFirst in BUSY restarts one.
  assign oReady     = !valid_q || iReady;
  assign accept     = iValid && oReady;
  assign first_beat = (state_q == IDLE) || iFirst;
  assign sub_eff    = first_beat ? iSub : mode_q;
  assign b_eff      = sub_eff ? ~iB : iB;
  assign cin        = first_beat ? (iSub | iC) : carry_q;
  assign cnt_next   = first_beat ? (CNT_W+1)'(1) : {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign len_err    = accept && !iLast && (cnt_next > (CNT_W+1)'(MAX_WORDS));

  adder_128bit #(.WIDTH(ADDER_WIDTH)) u_adder (
    .iA  (iA),
    .iB  (b_eff),
    .iC  (cin),
    .oSum(sum),
    .oC  (cout)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = (iLast || len_err) ? IDLE : BUSY;
  end

`ifdef ADDER_SEQ_OVF_EN
  logic ovf_q, ovf_d, msb_cin;
  assign msb_cin = iA[ADDER_WIDTH-1] ^ b_eff[ADDER_WIDTH-1] ^ sum[ADDER_WIDTH-1];
`endif

  always_comb begin
    carry_d = carry_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    c_d     = c_q;
    err_d   = err_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      carry_d = cout;
      mode_d  = sub_eff;
      cnt_d   = len_err ? '0 : cnt_next[CNT_W-1:0];
      valid_d = 1'b1;
      sum_d   = sum;
      last_d  = iLast || len_err;
      c_d     = iLast & cout;
      err_d   = len_err;
`ifdef ADDER_SEQ_OVF_EN
      ovf_d   = iLast & (msb_cin ^ cout);
`endif
    end else if (iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      c_q     <= c_d;
      err_q   <= err_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign oValid = valid_q;
  assign oSum   = sum_q;
  assign oLast  = last_q;
  assign oC     = c_q;
  assign oErr   = err_q;
`ifdef ADDER_SEQ_OVF_EN
  assign oOvf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_mp_sequencer.sv
// Bench for adder_mp_sequencer: big-number reference model plus directed literal checks, MAX_WORDS=4.

module tb_adder_mp_sequencer;
  localparam int W    = 128;
  localparam int MAXW = 4;
  localparam int NW   = 6;
  localparam int BW   = NW * W;

  logic clk, iRst_n, iValid, oReady, iC, iSub, iFirst, iLast;
  logic oValid, iReady, oLast, oC, oErr;
  logic [W-1:0] iA, iB, oSum;
`ifdef ADDER_SEQ_OVF_EN
  logic oOvf;
`endif

  adder_mp_sequencer #(.ADDER_WIDTH(W), .MAX_WORDS(MAXW)) dut (
    .iClk(clk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iC(iC), .iSub(iSub), .iFirst(iFirst), .iLast(iLast),
    .oValid(oValid), .iReady(iReady), .oSum(oSum), .oLast(oLast), .oC(oC), .oErr(oErr)
`ifdef ADDER_SEQ_OVF_EN
    , .oOvf(oOvf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Literal expectations posted by the stimulus process, checked by the compare process.
  bit           lit_en = 1'b0;
  logic [W-1:0] lit_sum;
  logic         lit_c, lit_last, lit_err, lit_rdy;
  bit           rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operand words kept as whole big numbers; each output word is
  // the matching word of the full-precision sum of the words received so far.
  bit           m_valid, m_last, m_c, m_err, m_ovf, in_op, m_sub, m_cin;
  logic [W-1:0] m_sum;
  logic [BW-1:0] op_a, op_b, mask, tb_eff;
  logic [BW:0]   tot;
  int            n;

  initial begin
    forever begin
      @(negedge clk);
      if (!iRst_n) begin
        chk("rst_valid", W'(oValid), '0);
        chk("rst_ready", W'(oReady), W'(1));
        chk("rst_sum", oSum, '0);
        chk("rst_last", W'(oLast), '0);
        chk("rst_c", W'(oC), '0);
        chk("rst_err", W'(oErr), '0);
        m_valid = 0; in_op = 0; n = 0;
      end else begin
        chk("valid", W'(oValid), W'(m_valid));
        chk("ready", W'(oReady), W'(!m_valid || iReady));
        if (m_valid) begin
          chk("sum", oSum, m_sum);
          chk("last", W'(oLast), W'(m_last));
          chk("carry", W'(oC), W'(m_c));
          chk("err", W'(oErr), W'(m_err));
`ifdef ADDER_SEQ_OVF_EN
          chk("ovf", W'(oOvf), W'(m_ovf));
`endif
        end
        if (lit_en) begin
          chk("lit_valid", W'(oValid), W'(1));
          chk("lit_sum", oSum, lit_sum);
          chk("lit_carry", W'(oC), W'(lit_c));
          chk("lit_last", W'(oLast), W'(lit_last));
          chk("lit_err", W'(oErr), W'(lit_err));
          chk("lit_ready", W'(oReady), W'(lit_rdy));
`ifdef ADDER_SEQ_OVF_EN
          chk("lit_ovf", W'(oOvf), '0);
`endif
        end
        if (iValid && (!m_valid || iReady)) begin
          if (!in_op || iFirst) begin
            op_a = '0; op_b = '0; n = 0;
            m_sub = iSub; m_cin = iSub | iC;
          end
          op_a[n*W +: W] = iA;
          op_b[n*W +: W] = iB;
          n++;
          mask   = {BW{1'b1}} >> (BW - n*W);
          tb_eff = (m_sub ? ~op_b : op_b) & mask;
          tot    = {1'b0, op_a & mask} + {1'b0, tb_eff} + (BW+1)'(m_cin);
          m_err  = !iLast && (n > MAXW);
          m_valid = 1;
          m_sum  = tot[(n-1)*W +: W];
          m_last = iLast || m_err;
          m_c    = iLast && tot[n*W];
          m_ovf  = iLast && (op_a[n*W-1] ^ tb_eff[n*W-1] ^ tot[n*W-1] ^ tot[n*W]);
          in_op  = !(iLast || m_err);
        end else if (iReady) begin
          m_valid = 0;
        end
      end
    end
  end

  function automatic logic [W-1:0] rword();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      2:       return W'(1);
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  task automatic step();
    if (rand_rdy) iReady = ($urandom_range(0, 3) != 0);
    @(posedge clk); #1;
  endtask

  // Drive one beat and wait until it is taken; iValid is left high on return.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic sub, input logic first, input logic last);
    bit done = 0;
    iA = a; iB = b; iC = c; iSub = sub; iFirst = first; iLast = last; iValid = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      if (rand_rdy) iReady = ($urandom_range(0, 3) != 0);
      @(negedge clk); done = oReady;
      @(posedge clk); #1;
    end
    if (!done) begin
      $display("FAIL accept_timeout: oReady stayed 0, expected 1 within 60 cycles");
      $fatal(1);
    end
  endtask

  task automatic expect_now(input logic [W-1:0] s, input logic c, input logic last,
                            input logic err, input logic rdy);
    lit_sum = s; lit_c = c; lit_last = last; lit_err = err; lit_rdy = rdy;
    lit_en = 1'b1;
    @(negedge clk); #1;
    lit_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    iRst_n = 0; iValid = 0; iReady = 1; iA = '0; iB = '0;
    iC = 0; iSub = 0; iFirst = 0; iLast = 0;
    repeat (2) @(posedge clk);
    #1 iRst_n = 1;
    @(posedge clk); #1;

    // single word with carry out
    send('1, W'(1), 0, 0, 1, 1); iValid = 0;
    expect_now('0, 1, 1, 0, 1);

    // 256-bit add: carry crosses the word boundary
    send('1, W'(1), 0, 0, 1, 0); iValid = 0;
    expect_now('0, 0, 0, 0, 1);
    send('0, '0, 0, 0, 0, 1); iValid = 0;
    expect_now(W'(1), 0, 1, 0, 1);

    // subtract with borrow
    send('0, W'(1), 0, 1, 1, 1); iValid = 0;
    expect_now('1, 0, 1, 0, 1);

    // backpressure: result held while the next word waits
    iReady = 0;
    send(W'(7), W'(1), 0, 0, 1, 1);
    iA = W'(20); iB = W'(2); iFirst = 1; iLast = 1;
    repeat (3) expect_now(W'(8), 0, 1, 0, 0);
    iReady = 1;
    send(W'(20), W'(2), 0, 0, 1, 1);
    send(W'(100), W'(1), 0, 0, 1, 1); iValid = 0;
    expect_now(W'(101), 0, 1, 0, 1);

    // reset mid-operand, then no carry leaks into the next operand
    send('1, W'(1), 0, 0, 1, 0); iValid = 0;
    #2 iRst_n = 0;
    @(posedge clk); #3 iRst_n = 1;
    @(posedge clk); #1;
    send('0, '0, 0, 0, 1, 1); iValid = 0;
    expect_now('0, 0, 1, 0, 1);

    // length error on the fifth word, then a fresh first beat using iC
    for (int w = 0; w < 5; w++) begin
      send('1, '0, 1, 0, (w == 0), 0); iValid = 0;
      expect_now('0, 0, (w == 4), (w == 4), 1);
    end
    send(W'(5), '0, 0, 0, 0, 1); iValid = 0;
    expect_now(W'(5), 0, 1, 0, 1);

    // randomized operands with gaps, aborts and random backpressure
    rand_rdy = 1;
    for (int op = 0; op < 150; op++) begin
      int len;
      bit sub;
      len = $urandom_range(1, 5);
      sub = $urandom_range(0, 1);
      for (int w = 0; w < len; w++) begin
        send(rword(), rword(), $urandom_range(0, 1), sub,
             (w == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0),
             (w == len - 1) && (len <= MAXW));
        if ($urandom_range(0, 3) == 0) begin
          iValid = 0;
          step();
        end
      end
    end
    rand_rdy = 0;
    iValid = 0; iReady = 1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
